// File: rtl/bc_skid_pkg.sv
// Shared types for the two-entry valid/ready skid slice.
// Holds the controller state encoding, the main-register source select
// and the occupancy constants reported on oCnt.
package bc_skid_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

  // Source of the next main-register value.
  typedef enum logic {
    SEL_IN   = 1'b0,
    SEL_SKID = 1'b1
  } main_sel_t;

  localparam logic [1:0] CNT_EMPTY = 2'd0;
  localparam logic [1:0] CNT_BUSY  = 2'd1;
  localparam logic [1:0] CNT_FULL  = 2'd2;

  function automatic logic [1:0] occupancy(input skid_state_t s);
    case (s)
      BUSY:    return CNT_BUSY;
      FULL:    return CNT_FULL;
      default: return CNT_EMPTY;
    endcase
  endfunction

endpackage

// File: rtl/bc_skid_ctrl.sv
// Skid-slice controller: EMPTY/BUSY/FULL FSM plus registered handshake flags.
// Latency: flags are flopped from the next state, so they describe the slice after each edge.
// Backpressure: o_rdy drops on the edge that fills the skid entry and returns on the edge leaving FULL.
// Ports: i_vld/i_rdy handshake inputs; o_rdy/o_vld/o_cnt registered outputs;
//        main_ld/main_sel/skid_ld steer the two data registers in the top.
module bc_skid_ctrl
  import bc_skid_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_vld,
  input  logic       i_rdy,
  output logic       o_rdy,
  output logic       o_vld,
  output logic [1:0] o_cnt,
  output logic       main_ld,
  output main_sel_t  main_sel,
  output logic       skid_ld
);

  skid_state_t state_q, state_d;
  logic        init_done_q, init_done_d;
  logic        rdy_q, rdy_d;
  logic        vld_q, vld_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        in_fire, out_fire;

  assign in_fire  = i_vld & rdy_q;
  assign out_fire = vld_q & i_rdy;

  always_comb begin
    state_d  = state_q;
    main_ld  = 1'b0;
    main_sel = SEL_IN;
    skid_ld  = 1'b0;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d = BUSY;
          main_ld = 1'b1;
        end
      end
      BUSY: begin
        if (in_fire && out_fire) begin
          main_ld = 1'b1;
        end else if (in_fire) begin
          // Downstream stalled: park the new word in the skid entry.
          state_d = FULL;
          skid_ld = 1'b1;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // rdy_q is low here, so only the drain can happen.
        if (out_fire) begin
          state_d  = BUSY;
          main_ld  = 1'b1;
          main_sel = SEL_SKID;
        end
      end
      default: state_d = EMPTY;
    endcase

    // Any edge out of reset completes initialisation; ready stays low until then.
    init_done_d = 1'b1;
    rdy_d       = init_done_d & (state_d != FULL);
    vld_d       = (state_d != EMPTY);
    cnt_d       = occupancy(state_d);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= EMPTY;
      init_done_q <= 1'b0;
      rdy_q       <= 1'b0;
      vld_q       <= 1'b0;
      cnt_q       <= CNT_EMPTY;
    end else begin
      state_q     <= state_d;
      init_done_q <= init_done_d;
      rdy_q       <= rdy_d;
      vld_q       <= vld_d;
      cnt_q       <= cnt_d;
    end
  end

  assign o_rdy = rdy_q & init_done_q;
  assign o_vld = vld_q;
  assign o_cnt = cnt_q;

endmodule

// File: rtl/bc_vld_rdy_skid_buf.sv
// Two-entry valid/ready register slice; both forward data and ready are flopped.
// Latency: one cycle; sustains one transfer per cycle while downstream is ready.
// Backpressure: accepts at most one extra word after iRdy drops, then deasserts oRdy.
// Ports: clk; rst (async, active low); iVld/iDat/oRdy upstream; oVld/oDat/iRdy downstream;
//        oCnt occupancy (0..2).
module bc_vld_rdy_skid_buf
  import bc_skid_pkg::*;
#(
  parameter int          WIDTH    = 32,
  parameter logic [31:0] INI_DATA = 32'h0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iVld,
  input  logic [WIDTH-1:0] iDat,
  output logic             oRdy,
  output logic             oVld,
  output logic [WIDTH-1:0] oDat,
  input  logic             iRdy,
  output logic [1:0]       oCnt
);

  localparam logic [WIDTH-1:0] INI_W = WIDTH'(INI_DATA);

  logic             main_ld;
  logic             skid_ld;
  main_sel_t        main_sel;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;

  bc_skid_ctrl u_ctrl (
    .clk      (clk),
    .rst      (rst),
    .i_vld    (iVld),
    .i_rdy    (iRdy),
    .o_rdy    (oRdy),
    .o_vld    (oVld),
    .o_cnt    (oCnt),
    .main_ld  (main_ld),
    .main_sel (main_sel),
    .skid_ld  (skid_ld)
  );

  always_comb begin
    main_d = (main_sel == SEL_SKID) ? skid_q : iDat;
    skid_d = iDat;
  end

  // Enable registers: contents change only on the load strobes from the controller.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_q <= INI_W;
    end else if (main_ld) begin
      main_q <= main_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      skid_q <= INI_W;
    end else if (skid_ld) begin
      skid_q <= skid_d;
    end
  end

  assign oDat = main_q;

endmodule
